// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: sync + de-glitch lines, deserialise 11-bit frames, fold E0/F0 prefixes.
// Emits one registered strobe per make code (key_valid) or per discarded frame (frame_err).
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keyboard_out,
    output logic        key_valid,
    output logic        frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_s, data_s;
    logic [FW-1:0] filt_cnt;
    logic          filt_lvl;
    logic          flip, fall;
    state_t        state, state_nxt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_ok;
    logic [TW-1:0] tcnt;
    logic          ext, brk;
    logic          frame_done, timeout, good, bad;

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    // Synchronisers idle high so reset does not fabricate a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign flip = (clk_s != filt_lvl) && (filt_cnt == FW'(FILTER_LEN - 1));
    assign fall = flip && filt_lvl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_cnt <= '0;
            filt_lvl <= 1'b1;
        end else if (clk_s == filt_lvl) begin
            filt_cnt <= '0;
        end else if (flip) begin
            filt_lvl <= clk_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        timeout    = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));
        case (state)
            IDLE:   if (fall && !data_s) state_nxt = DATA;
            DATA:   if (fall && bit_cnt == 3'd7) state_nxt = PARITY;
            PARITY: if (fall) state_nxt = STOP;
            STOP: begin
                if (fall) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (timeout) state_nxt = IDLE;
    end

    assign good = frame_done && par_ok && data_s;
    assign bad  = (frame_done && !good) || timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par_ok  <= 1'b0;
            tcnt    <= '0;
        end else begin
            if (fall || state == IDLE) tcnt <= '0;
            else                       tcnt <= tcnt + 1'b1;
            if (fall) begin
                case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: par_ok <= ^{shreg, data_s};
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keyboard_out <= '0;
            key_valid    <= 1'b0;
            frame_err    <= 1'b0;
            ext          <= 1'b0;
            brk          <= 1'b0;
        end else begin
            keyboard_out <= '0;
            key_valid    <= 1'b0;
            frame_err    <= 1'b0;
            if (bad) begin
                frame_err <= 1'b1;
                ext       <= 1'b0;
                brk       <= 1'b0;
            end else if (good) begin
                case (shreg)
                    8'hE0: ext <= 1'b1;
                    8'hF0: brk <= 1'b1;
                    8'h00, 8'hFF: begin
                        ext <= 1'b0;
                        brk <= 1'b0;
                    end
                    default: begin
                        // A byte following F0 is a key release and is dropped.
                        if (!brk) begin
                            keyboard_out <= {ext ? 8'hE0 : 8'h00, shreg};
                            key_valid    <= 1'b1;
                        end
                        ext <= 1'b0;
                        brk <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: stimulus queues expected strobes, a monitor pops on each strobe.
module tb_ps2_keyboard_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] keyboard_out;
    logic        key_valid;
    logic        frame_err;

    int total = 0;
    int bad = 0;
    logic [16:0] expq[$];

    ps2_keyboard_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(2000)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keyboard_out(keyboard_out), .key_valid(key_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            wait_cyc(20);
            ps2_clk = 1'b0;
            wait_cyc(2);
            ps2_clk = 1'b1;
            wait_cyc(28);
        end else begin
            wait_cyc(50);
        end
        ps2_clk = 1'b0;
        wait_cyc(50);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop, input int glitch_bit);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = (~^b) ^ bad_par;
        f[10]  = stop;
        for (int i = 0; i < 11; i++) send_bit(f[i], i == glitch_bit);
        ps2_data = 1'b1;
        wait_cyc(30);
    endtask

    task automatic exp_key(input logic [15:0] code);
        expq.push_back({1'b0, code});
    endtask

    task automatic exp_err();
        expq.push_back({1'b1, 16'h0000});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (key_valid && frame_err) begin
                bad++;
                $display("FAIL both_strobes: key_valid=1 frame_err=1 want not both");
            end
            total++;
            if (!key_valid && keyboard_out !== 16'h0000) begin
                bad++;
                $display("FAIL idle_out: got %h want 0000", keyboard_out);
            end
            if (key_valid || frame_err) begin
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_strobe: kv=%b err=%b out=%h want none", key_valid, frame_err, keyboard_out);
                end else begin
                    logic [16:0] e;
                    e = expq.pop_front();
                    if ({frame_err, keyboard_out} !== e) begin
                        bad++;
                        $display("FAIL strobe: got err=%b out=%h want err=%b out=%h",
                                 frame_err, keyboard_out, e[16], e[15:0]);
                    end
                end
            end
        end
    end

    initial begin
        wait_cyc(3);
        check("reset_out", {16'h0, keyboard_out}, 32'h0);
        check("reset_kv", {31'h0, key_valid}, 32'h0);
        check("reset_err", {31'h0, frame_err}, 32'h0);
        rst = 1'b0;
        wait_cyc(20);

        exp_key(16'h001C); send_frame(8'h1C, 0, 1'b1, -1);

        exp_key(16'hE075);
        send_frame(8'hE0, 0, 1'b1, -1);
        send_frame(8'h75, 0, 1'b1, -1);
        send_frame(8'hF0, 0, 1'b1, -1);
        send_frame(8'h1C, 0, 1'b1, -1);
        exp_key(16'h005A); send_frame(8'h5A, 0, 1'b1, -1);

        send_frame(8'hF0, 0, 1'b1, -1);
        send_frame(8'hE0, 0, 1'b1, -1);
        send_frame(8'h75, 0, 1'b1, -1);
        exp_key(16'h001C); send_frame(8'h1C, 0, 1'b1, -1);
        exp_key(16'h001C); send_frame(8'h1C, 0, 1'b1, -1);

        send_frame(8'hFF, 0, 1'b1, -1);

        exp_err(); send_frame(8'h1C, 1, 1'b1, -1);
        exp_err(); send_frame(8'h1C, 0, 1'b0, -1);
        exp_key(16'h0016); send_frame(8'h16, 0, 1'b1, -1);

        ps2_clk = 1'b0; wait_cyc(2); ps2_clk = 1'b1; wait_cyc(20);
        exp_key(16'h0045); send_frame(8'h45, 0, 1'b1, 4);

        exp_err();
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        ps2_data = 1'b1;
        wait_cyc(2200);
        exp_key(16'h0024); send_frame(8'h24, 0, 1'b1, -1);

        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        rst = 1'b1;
        wait_cyc(3);
        check("midrst_out", {16'h0, keyboard_out}, 32'h0);
        check("midrst_kv", {31'h0, key_valid}, 32'h0);
        check("midrst_err", {31'h0, frame_err}, 32'h0);
        rst = 1'b0;
        ps2_data = 1'b1;
        wait_cyc(20);
        exp_key(16'h002B); send_frame(8'h2B, 0, 1'b1, -1);

        wait_cyc(100);
        check("queue_empty", expq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

PS/2 keyboard receiver that sits directly upstream of the keypad hex-entry stage. It synchronises and de-glitches the raw PS/2 clock/data lines and deserialises 11-bit device-to-host frames, checking start, parity and stop bits. Prefix bytes (E0 extended, F0 break) are folded into a 16-bit code word. The word is presented as a single-cycle pulse on `keyboard_out`, so the downstream stage acts exactly once per key press.

## Interface
- `FILTER_LEN`, 8: consecutive identical synchronised samples of `ps2_clk` required before the filtered level changes.
- `TIMEOUT_CYCLES`, 100000: `clk` cycles without a filtered falling edge, mid-frame, before the frame is aborted.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ps2_clk` in 1: raw PS/2 clock line (asynchronous).
- `ps2_data` in 1: raw PS/2 data line (asynchronous).
- `keyboard_out` out 16: [15:8] prefix (8'hE0 or 8'h00), [7:0] make code. Equals 16'h0000 whenever `key_valid` is 0.
- `key_valid` out 1: one-cycle strobe qualifying `keyboard_out`.
- `frame_err` out 1: one-cycle strobe on any discarded frame.

## Operation
- **Input conditioning**
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser.
  - Synchronised `ps2_clk` feeds a saturating filter counter. The filtered level flips only after `FILTER_LEN` consecutive samples differ from it.
  - Filtered level resets to 1.
  - A filtered 1->0 transition is a "falling edge". Synchronised `ps2_data` is sampled in the same cycle.
- **Frame FSM**, states IDLE, DATA, PARITY, STOP:
  - IDLE: on a falling edge with data 0, go to DATA with bit counter 0. A falling edge with data 1 is ignored; stay in IDLE, no error.
  - DATA: shift data in LSB-first into an 8-bit shift register. After the 8th bit go to PARITY.
  - PARITY: require odd parity over the 8 data bits plus the parity bit, then go to STOP.
  - STOP: require data 1. Return to IDLE unconditionally.
- **Frame validity**
  - A frame is good only if parity and stop are both correct.
  - Any bad frame: `frame_err` pulses, byte discarded, prefix flags cleared.
- **Timeout**
  - Counter clears on every falling edge and whenever the FSM is in IDLE.
  - In DATA, PARITY or STOP, reaching `TIMEOUT_CYCLES` sends the FSM to IDLE, pulses `frame_err` and clears the prefix flags.
- **Byte decode** (good frames only):
  - 8'hE0: set `ext`. No output.
  - 8'hF0: set `brk`. No output.
  - 8'h00 or 8'hFF (keyboard error codes): discard, clear both flags. No output, no `frame_err`.
  - Any other byte, `brk`=1: suppress (key release) and clear both flags.
  - Any other byte, `brk`=0: output `{ext ? 8'hE0 : 8'h00, byte}` with `key_valid`=1, then clear both flags.
  - F0 then E0 (and E0 then F0) set both flags. The following byte is suppressed.
- **Repeats:** typematic repeats of a make code produce one pulse per received frame.
- **Reset values:** `keyboard_out`=0, `key_valid`=0, `frame_err`=0, FSM=IDLE, flags=0, all counters and the shift register 0.
  - Reset mid-frame abandons the frame.
  - After reset the receiver decodes the next frame whose start bit arrives once the filter has settled high.

## Timing
- Outputs are registered.
- `key_valid` / `frame_err` rise exactly 1 `clk` cycle after the cycle in which the stop-bit falling edge is detected (or the timeout count is reached). They stay high for exactly 1 cycle.
- Raw line to detected edge: 2 synchroniser cycles plus `FILTER_LEN` filter cycles.
- `key_valid` and `frame_err` are never high in the same cycle.
- Back-to-back frames need no idle gap beyond the PS/2 line timing. A new start bit may arrive in the cycle after STOP.

## Test plan
Bench parameters: `FILTER_LEN`=4, `TIMEOUT_CYCLES`=2000, PS/2 half-period 50 `clk` cycles.
- **Make code:** frame 8'h1C with parity 0 and stop 1 -> one cycle of `keyboard_out`=16'h001C, `key_valid`=1. Then 16'h0000, `frame_err` never high.
- **Extended and break:** frames E0, 75 -> single pulse 16'hE075. Frames F0, 1C -> no `key_valid`. A following 5A -> 16'h005A.
- **Framing errors:** 8'h1C with parity bit 1 -> `frame_err` one-cycle pulse, no `key_valid`. Stop bit 0 -> same. Next good 8'h16 -> 16'h0016.
- **Glitch rejection:** 2-cycle low glitches on `ps2_clk` during idle and mid-bit -> no bit shifted, subsequent 8'h45 frame decodes to 16'h0045.
- **Timeout:** start bit plus 4 data bits, then lines idle for 2000 cycles -> `frame_err` pulse. Next full 8'h24 frame -> 16'h0024.
- **Reset mid-frame:** `rst` asserted for 3 cycles during DATA -> all outputs 0 immediately. Next full 8'h2B frame -> 16'h002B, no `frame_err`.
